// File: rtl/mac_feed_sequencer.sv
`default_nettype none
// ============================================================================
// mac_feed_sequencer: walks pixel/group/beat, issues buffer reads and aligned
// MAC valid/clear/result strobes.            Revision: 1.0
// ============================================================================
module mac_feed_sequencer #(
  parameter int LANES    = 10,
  parameter int IN_CH    = 40,
  parameter int OUT_CH   = 80,
  parameter int PE       = 16,
  parameter int PIPE_LAT = 10,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixel_num,
  input  logic              src_ready,
  output logic              busy,
  output logic              done,
  output logic              fmap_rd_en,
  output logic [ADDR_W-1:0] fmap_rd_addr,
  output logic              param_rd_en,
  output logic [ADDR_W-1:0] param_rd_addr,
  output logic              mac_in_valid,
  output logic              mac_acc_clr,
  output logic              mac_out_valid,
  output logic [PIX_W-1:0]  out_pix,
  output logic [7:0]        out_grp
);

  localparam int BEATS   = IN_CH / LANES;
  localparam int REPEATS = OUT_CH / PE;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [PIX_W-1:0]  pix_cnt;
  logic [PIX_W-1:0]  pix_last;
  logic [7:0]        grp_cnt;
  logic [BEAT_W-1:0] beat_cnt;

  logic issue;
  logic beat_wrap;
  logic grp_wrap;
  logic pix_wrap;
  logic final_rd;
  logic pending;

  logic             in_last;
  logic [PIX_W-1:0] in_pix;
  logic [7:0]       in_grp;

  logic [PIPE_LAT-1:0] dl_last;
  logic [PIX_W-1:0]    dl_pix [PIPE_LAT];
  logic [7:0]          dl_grp [PIPE_LAT];

  assign issue     = (state == S_RUN) && src_ready;
  assign beat_wrap = (beat_cnt == BEAT_W'(BEATS - 1));
  assign grp_wrap  = (grp_cnt == 8'(REPEATS - 1));
  assign pix_wrap  = (pix_cnt == pix_last);
  assign final_rd  = issue && beat_wrap && grp_wrap && pix_wrap;

  assign fmap_rd_en  = issue;
  assign param_rd_en = issue;

  // Products taken modulo 2^ADDR_W; truncating operands first gives the same low bits.
  assign fmap_rd_addr  = ADDR_W'(pix_cnt) * ADDR_W'(BEATS) + ADDR_W'(beat_cnt);
  assign param_rd_addr = ADDR_W'(grp_cnt) * ADDR_W'(BEATS) + ADDR_W'(beat_cnt);

  // The tap entry leaves on this edge, so only upstream stages keep the drain open.
  assign pending = mac_in_valid | (|(dl_last << 1));

  assign mac_out_valid = dl_last[PIPE_LAT-1];
  assign out_pix       = dl_pix[PIPE_LAT-1];
  assign out_grp       = dl_grp[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pix_cnt  <= '0;
      pix_last <= '0;
      grp_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            pix_cnt  <= '0;
            grp_cnt  <= '0;
            beat_cnt <= '0;
            pix_last <= pixel_num - PIX_W'(1);
            state    <= (pixel_num != '0) ? S_RUN : S_DRAIN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (final_rd) begin
              state    <= S_DRAIN;
              pix_cnt  <= '0;
              grp_cnt  <= '0;
              beat_cnt <= '0;
            end else if (beat_wrap) begin
              beat_cnt <= '0;
              if (grp_wrap) begin
                grp_cnt <= '0;
                pix_cnt <= pix_cnt + PIX_W'(1);
              end else begin
                grp_cnt <= grp_cnt + 8'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!pending) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mac_in_valid <= 1'b0;
      mac_acc_clr  <= 1'b0;
      in_last      <= 1'b0;
      in_pix       <= '0;
      in_grp       <= '0;
      dl_last      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_pix[i] <= '0;
        dl_grp[i] <= '0;
      end
    end else begin
      mac_in_valid <= issue;
      mac_acc_clr  <= issue && (beat_cnt == '0);
      in_last      <= issue && beat_wrap;
      in_pix       <= pix_cnt;
      in_grp       <= grp_cnt;
      dl_last[0]   <= in_last;
      dl_pix[0]    <= in_pix;
      dl_grp[0]    <= in_grp;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_last[i] <= dl_last[i-1];
        dl_pix[i]  <= dl_pix[i-1];
        dl_grp[i]  <= dl_grp[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_feed_sequencer.sv
`default_nettype none
// Bench for mac_feed_sequencer: default and swept configurations, table vectors,
// corner sequences and random stalls against a cycle-indexed job model.
module tb_mac_feed_sequencer;

  localparam int MAXC = 320;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        src_ready;
  logic        sel;
  logic [15:0] pixel_num;

  always #5 clk = ~clk;

  logic        start0, start1;
  logic        busy0, done0, fre0, pre0, miv0, clr0, mov0;
  logic        busy1, done1, fre1, pre1, miv1, clr1, mov1;
  logic [15:0] fa0, pa0, op0, fa1, pa1, op1;
  logic [7:0]  og0, og1;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  mac_feed_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start0), .pixel_num(pixel_num), .src_ready(src_ready),
    .busy(busy0), .done(done0), .fmap_rd_en(fre0), .fmap_rd_addr(fa0),
    .param_rd_en(pre0), .param_rd_addr(pa0), .mac_in_valid(miv0), .mac_acc_clr(clr0),
    .mac_out_valid(mov0), .out_pix(op0), .out_grp(og0)
  );

  mac_feed_sequencer #(
    .LANES(8), .IN_CH(64), .OUT_CH(32), .PE(16), .PIPE_LAT(4), .PIX_W(16), .ADDR_W(16)
  ) dut_sweep (
    .clk(clk), .rstn(rstn), .start(start1), .pixel_num(pixel_num), .src_ready(src_ready),
    .busy(busy1), .done(done1), .fmap_rd_en(fre1), .fmap_rd_addr(fa1),
    .param_rd_en(pre1), .param_rd_addr(pa1), .mac_in_valid(miv1), .mac_acc_clr(clr1),
    .mac_out_valid(mov1), .out_pix(op1), .out_grp(og1)
  );

  logic        busy, done, fre, pre, miv, clr, mov;
  logic [15:0] fa, pa, op;
  logic [7:0]  og;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign fre  = sel ? fre1  : fre0;
  assign pre  = sel ? pre1  : pre0;
  assign miv  = sel ? miv1  : miv0;
  assign clr  = sel ? clr1  : clr0;
  assign mov  = sel ? mov1  : mov0;
  assign fa   = sel ? fa1   : fa0;
  assign pa   = sel ? pa1   : pa0;
  assign op   = sel ? op1   : op0;
  assign og   = sel ? og1   : og0;

  int nvec = 0;
  int nbad = 0;
  int cur_cycle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cur_cycle, act, exp);
    end
  endtask

  // Expected per-cycle behaviour of one job, derived from the read order rules.
  bit e_rd  [MAXC];
  bit e_inv [MAXC];
  bit e_clr [MAXC];
  bit e_ov  [MAXC];
  int e_fa  [MAXC];
  int e_pa  [MAXC];
  int e_op  [MAXC];
  int e_og  [MAXC];

  task automatic run_job(input int p, input int lo, input int hi, input bit rnd,
                         input int restart_at,
                         output int n_rd, output int n_res, output int n_clr,
                         output int first_out, output int done_c,
                         output int last_pix, output int last_grp);
    int B, R, L, total, idx, c, clast, edone;
    bit rdy [MAXC];
    B = sel ? 8 : 4;
    R = sel ? 2 : 5;
    L = sel ? 4 : 10;
    for (int k = 0; k < MAXC; k++) begin
      e_rd[k] = 0; e_inv[k] = 0; e_clr[k] = 0; e_ov[k] = 0;
      e_fa[k] = 0; e_pa[k] = 0; e_op[k] = 0; e_og[k] = 0;
      rdy[k] = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (k >= lo && k <= hi) rdy[k] = 1'b0;
      if (k >= 150) rdy[k] = 1'b1;
    end
    total = p * R * B;
    idx = 0; c = 1; clast = 0;
    while (idx < total) begin
      if (rdy[c]) begin
        e_rd[c]    = 1;
        e_fa[c]    = (idx / (B * R)) * B + idx % B;
        e_pa[c]    = ((idx / B) % R) * B + idx % B;
        e_inv[c+1] = 1;
        e_clr[c+1] = (idx % B == 0);
        if (idx % B == B - 1) begin
          e_ov[c+1+L] = 1;
          e_op[c+1+L] = idx / (B * R);
          e_og[c+1+L] = (idx / B) % R;
        end
        idx++;
        clast = c;
      end
      c++;
    end
    edone = clast + L + 2;

    n_rd = 0; n_res = 0; n_clr = 0; first_out = -1; done_c = -1; last_pix = -1; last_grp = -1;
    @(negedge clk);
    start = 1'b1; pixel_num = 16'(p); src_ready = rdy[0];
    for (int cy = 1; cy <= edone + 2; cy++) begin
      @(posedge clk); #1;
      start = (cy == restart_at);
      if (cy == restart_at) pixel_num = 16'd7;
      src_ready = rdy[cy];
      @(negedge clk);
      cur_cycle = cy;
      chk("busy", 32'(busy), 32'(cy < edone));
      chk("done", 32'(done), 32'(cy == edone));
      chk("fmap_rd_en", 32'(fre), 32'(e_rd[cy]));
      chk("param_rd_en", 32'(pre), 32'(e_rd[cy]));
      if (e_rd[cy]) begin
        chk("fmap_rd_addr", 32'(fa), 32'(e_fa[cy]));
        chk("param_rd_addr", 32'(pa), 32'(e_pa[cy]));
      end
      chk("mac_in_valid", 32'(miv), 32'(e_inv[cy]));
      chk("mac_acc_clr", 32'(clr), 32'(e_clr[cy]));
      chk("mac_out_valid", 32'(mov), 32'(e_ov[cy]));
      if (e_ov[cy]) begin
        chk("out_pix", 32'(op), 32'(e_op[cy]));
        chk("out_grp", 32'(og), 32'(e_og[cy]));
      end
      if (fre) n_rd++;
      if (clr && miv) n_clr++;
      if (mov) begin
        n_res++;
        if (first_out < 0) first_out = cy;
        last_pix = int'(op);
        last_grp = int'(og);
      end
      if (done && done_c < 0) done_c = cy;
    end
    start = 1'b0;
  endtask

  typedef struct {
    bit sel;
    int p, lo, hi;
    int reads, results, first_out, done_c, last_pix, last_grp;
  } vec_t;

  vec_t tbl [5];
  int n_rd, n_res, n_clr, fo, dc, lp, lg;

  initial begin
    tbl[0] = '{0, 2, -1, -1, 40, 10, 15, 52, 1, 4};
    tbl[1] = '{0, 2,  3,  5, 40, 10, 18, 55, 1, 4};
    tbl[2] = '{0, 1, -1, -1, 20,  5, 15, 32, 0, 4};
    tbl[3] = '{0, 3, -1, -1, 60, 15, 15, 72, 2, 4};
    tbl[4] = '{1, 3, -1, -1, 48,  6, 13, 54, 2, 1};

    rstn = 1'b0; start = 1'b0; src_ready = 1'b0; sel = 1'b0; pixel_num = '0;
    #12;
    cur_cycle = 0;
    chk("reset busy", 32'(busy0 | busy1), 0);
    chk("reset done", 32'(done0 | done1), 0);
    chk("reset rd_en", 32'(fre0 | pre0 | fre1 | pre1), 0);
    chk("reset mac strobes", 32'(miv0 | clr0 | mov0 | miv1 | clr1 | mov1), 0);
    chk("reset addrs", 32'(fa0 | pa0 | fa1 | pa1), 0);
    chk("reset out_pix/grp", 32'(op0 | op1 | 16'(og0) | 16'(og1)), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      sel = tbl[v].sel;
      run_job(tbl[v].p, tbl[v].lo, tbl[v].hi, 1'b0, 0, n_rd, n_res, n_clr, fo, dc, lp, lg);
      cur_cycle = v;
      chk("tbl reads", n_rd, tbl[v].reads);
      chk("tbl results", n_res, tbl[v].results);
      chk("tbl acc_clr count", n_clr, tbl[v].results);
      chk("tbl first result", fo, tbl[v].first_out);
      chk("tbl done cycle", dc, tbl[v].done_c);
      chk("tbl last pix", lp, tbl[v].last_pix);
      chk("tbl last grp", lg, tbl[v].last_grp);
    end
    sel = 1'b0;

    // Empty job: no traffic, done within PIPE_LAT+2, busy until done.
    begin
      bit seen;
      int zc;
      seen = 0; zc = 0;
      @(negedge clk);
      start = 1'b1; pixel_num = 16'd0; src_ready = 1'b1;
      for (int cy = 1; cy <= 14; cy++) begin
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        cur_cycle = cy;
        chk("zero rd_en", 32'(fre), 0);
        chk("zero mac_in_valid", 32'(miv), 0);
        chk("zero mac_out_valid", 32'(mov), 0);
        if (!seen && done) begin
          seen = 1; zc = cy;
          chk("zero busy at done", 32'(busy), 0);
        end else if (!seen) begin
          chk("zero busy before done", 32'(busy), 1);
        end else begin
          chk("zero busy after done", 32'(busy), 0);
          chk("zero done single pulse", 32'(done), 0);
        end
      end
      chk("zero done seen in time", 32'(seen && zc <= 12), 1);
    end

    // Start pulsed mid-job is ignored; a following job runs fully.
    run_job(2, -1, -1, 1'b0, 20, n_rd, n_res, n_clr, fo, dc, lp, lg);
    chk("restart results", n_res, 10);
    chk("restart reads", n_rd, 40);
    chk("restart done", dc, 52);
    run_job(2, -1, -1, 1'b0, 0, n_rd, n_res, n_clr, fo, dc, lp, lg);
    chk("second job results", n_res, 10);

    // Reset in the middle of a job.
    @(negedge clk);
    start = 1'b1; pixel_num = 16'd2; src_ready = 1'b1;
    repeat (24) begin
      @(posedge clk); #1 start = 1'b0;
    end
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    cur_cycle = 25;
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset rd_en", 32'(fre | pre), 0);
    chk("mid reset addrs", 32'(fa | pa), 0);
    chk("mid reset mac strobes", 32'(miv | clr | mov | done), 0);
    chk("mid reset out_pix/grp", 32'(op | 16'(og)), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int cy = 0; cy < 20; cy++) begin
      @(negedge clk);
      cur_cycle = cy;
      chk("post reset mac_out_valid", 32'(mov), 0);
      chk("post reset busy", 32'(busy | fre), 0);
    end
    run_job(2, -1, -1, 1'b0, 0, n_rd, n_res, n_clr, fo, dc, lp, lg);
    chk("post reset job results", n_res, 10);
    chk("post reset job first", fo, 15);

    // Random backpressure on both configurations.
    for (int k = 0; k < 6; k++) begin
      int p;
      sel = k[0];
      p = $urandom_range(1, 3);
      run_job(p, -1, -1, 1'b1, 0, n_rd, n_res, n_clr, fo, dc, lp, lg);
      cur_cycle = k;
      chk("rand results", n_res, p * (sel ? 2 : 5));
      chk("rand reads", n_rd, p * (sel ? 16 : 20));
      chk("rand acc_clr count", n_clr, n_res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_feed_sequencer.md
# mac_feed_sequencer

Parametrised controller that feeds the 16-PE MAC array from the feature-map and parameter buffers. It walks pixels, output-channel groups and input-channel beats, and issues buffer read addresses. It generates the MAC input-valid, accumulator-clear and output-valid strobes, aligned to a configurable MAC pipeline latency. The block sits between the layer controller (start/done) and the MAC array plus its two read buffers. It adds run-time pixel count, source backpressure and start/done handshaking.

## Interface
- LANES, 10, bytes per data beat (MAC input width = LANES*8)
- IN_CH, 40, input channels; must be a multiple of LANES; BEATS = IN_CH/LANES
- OUT_CH, 80, output channels; must be a multiple of PE; REPEATS = OUT_CH/PE
- PE, 16, output channels computed per accumulation
- PIPE_LAT, 10, cycles from last beat at MAC input to valid MAC result
- PIX_W, 16, width of pixel counter
- ADDR_W, 16, buffer address width

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- pixel_num  in  PIX_W  pixels to process; latched on accepted start
- src_ready  in  1  both buffers can serve a read this cycle
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, end of job
- fmap_rd_en  out  1  feature-map buffer read strobe
- fmap_rd_addr  out  ADDR_W  pixel*BEATS + beat
- param_rd_en  out  1  parameter buffer read strobe (equals fmap_rd_en)
- param_rd_addr  out  ADDR_W  group*BEATS + beat
- mac_in_valid  out  1  read data valid at MAC input (rd_en delayed 1 cycle)
- mac_acc_clr  out  1  with mac_in_valid: accumulator loads instead of adds (first beat of each accumulation)
- mac_out_valid  out  1  one-cycle strobe, MAC result valid
- out_pix  out  PIX_W  pixel index of current result, valid with mac_out_valid
- out_grp  out  8  output-channel group index of current result, valid with mac_out_valid

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on start with pixel_num ≠ 0.
- IDLE → DRAIN on start with pixel_num = 0: no reads are issued and done pulses after the empty drain.
- RUN: loop order is pixel (outer), group (middle), beat (inner). Each cycle with src_ready=1 issues one read and advances beat.
  - beat wraps at BEATS-1 and increments group.
  - group wraps at REPEATS-1 and increments pixel.
  - After the read of (pixel_num-1, REPEATS-1, BEATS-1), the FSM goes to DRAIN.
- src_ready=0 in RUN: no read, all counters hold, and a bubble appears at the MAC input. Accumulation integrity is preserved because acc_clr is tied to beat 0, not to time.
- DRAIN: wait until the output delay line is empty, then assert done for 1 cycle and return to IDLE. busy falls in the same cycle done rises.
- Delay line: a PIPE_LAT-deep shift register carries {last_beat, pixel, group} from the MAC input stage. mac_out_valid is driven by last_beat at the tap. Bubbles shift through as invalid.
- start while busy: ignored. pixel_num changes while busy: ignored.
- Reset (any time, including mid-job): FSM to IDLE and delay line flushed.
- Reset values: busy, done, rd_en, mac_in_valid, mac_acc_clr, mac_out_valid = 0; addresses, out_pix, out_grp = 0.
- Addresses are computed as full-width products truncated to ADDR_W. The integrator guarantees pixel_num*BEATS ≤ 2^ADDR_W.

## Timing
- Accepted start at edge 0.
- First rd_en at cycle 1, assuming src_ready=1.
- mac_in_valid lags rd_en by exactly 1 cycle. mac_acc_clr is coincident with the beat-0 mac_in_valid.
- Last beat at MAC input in cycle t → mac_out_valid in cycle t+PIPE_LAT.
- Back-to-back accumulations have no gap. Result strobes are spaced BEATS cycles apart when there is no stall.
- done = cycle after final mac_out_valid. A new start is accepted the cycle after done.
- Total cycles with no stall: pixel_num*REPEATS*BEATS + PIPE_LAT + 2 (from start to done).

## Test plan
- Defaults, pixel_num=2, src_ready=1:
  - 40 reads in cycles 1–40; fmap addrs 0,1,2,3 repeated 5×, then 4–7 repeated 5×; param addrs 0–19 per pixel.
  - 10 mac_out_valid pulses: first at cycle 15, last at 51 with out_pix=1, out_grp=4.
  - done at 52.
- Same job with src_ready low on cycles 3–5:
  - reads and results shift by 3 cycles; mac_acc_clr count = 10 and still only on beat 0; out_pix/out_grp sequence unchanged; done at 55.
- pixel_num=0:
  - no rd_en, no mac_in_valid, no mac_out_valid; done pulses within PIPE_LAT+2 cycles; busy high until then.
- start pulsed again at cycle 20 of a running job:
  - ignored; exactly 10 results produced; a second start after done runs a full second job.
- rstn low at cycle 25 mid-job:
  - all outputs 0 immediately; no mac_out_valid after reset release; next start runs a clean job from pixel 0, group 0.
- Parameter sweep LANES=8, IN_CH=64, OUT_CH=32, PE=16, PIPE_LAT=4, pixel_num=3:
  - BEATS=8, REPEATS=2, 48 reads, 6 results; first result at cycle 1+8+4=13.
